// File: rtl/hack_seq_pkg.sv
// Shared types for the Hack CPU run-control sequencer: FSM states and command encoding.
package hack_seq_pkg;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned CMD_W = 2;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        HALTED     = 2'd1,
        RUNNING    = 2'd2,
        STEPPING   = 2'd3
    } seq_state_e;

    localparam logic [CMD_W-1:0] CMD_RUN   = 2'd0;
    localparam logic [CMD_W-1:0] CMD_HALT  = 2'd1;
    localparam logic [CMD_W-1:0] CMD_STEP  = 2'd2;
    localparam logic [CMD_W-1:0] CMD_RESET = 2'd3;

endpackage

// File: rtl/hack_phase_counter.sv
// CPU step phase counter: counts 0..DIV-1, decodes the CPU phase clock and the
// boundary (last cycle) and commit (phase rise) strobes.
module hack_phase_counter
    import hack_seq_pkg::*;
#(
    parameter int unsigned DIV = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] CLK_COUNT,
    output logic             CLK_CPU,
    output logic             boundary_c,
    output logic             commit_c
);

    generate
        if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
            $error("hack_phase_counter: DIV must be even and >= 4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = CLK_COUNT;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (CLK_COUNT == LAST) ? '0 : CLK_COUNT + CNT_W'(1);
        end
    end

    // Phase clock is registered from the next count so it tracks CLK_COUNT exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            CLK_COUNT <= '0;
            CLK_CPU   <= 1'b0;
        end else begin
            CLK_COUNT <= count_d;
            CLK_CPU   <= (count_d >= HALF);
        end
    end

    assign boundary_c = enable && (CLK_COUNT == LAST);
    assign commit_c   = enable && (CLK_COUNT == HALF);

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Hack CPU run-control sequencer: reset hold, run/halt/step command handling, instruction count.
// Optional PC breakpoint halt is built when HACK_SEQ_BREAKPOINT_EN is defined.
module hack_cpu_sequencer
    import hack_seq_pkg::*;
#(
    parameter int unsigned DIV         = 20,
    parameter int unsigned RESET_STEPS = 2,
    parameter bit          AUTORUN     = 1'b0
) (
    input  logic             CLK_100MHz,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd,
    input  logic [15:0]      pc,
    input  logic             bp_en,
    input  logic [15:0]      bp_addr,
    output logic             CLK_CPU,
    output logic [CNT_W-1:0] CLK_COUNT,
    output logic             cpu_reset,
    output logic             halted,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned STEPS_EFF = (RESET_STEPS < 1) ? 1 : RESET_STEPS;
    localparam int unsigned STEP_W    = $clog2(STEPS_EFF + 1);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              pend_halt_q, pend_halt_d;
    logic              pend_reset_q, pend_reset_d;
    logic              step_done_d, bp_hit_d;
    logic [CNT_W-1:0]  instr_count_d;
    logic              accept, boundary_c, commit_c, bp_match_c;

    hack_phase_counter #(.DIV(DIV)) u_phase (
        .clk       (CLK_100MHz),
        .rst_n     (reset_n),
        .enable    (state_q != HALTED),
        .clear     (state_d != state_q),
        .CLK_COUNT (CLK_COUNT),
        .CLK_CPU   (CLK_CPU),
        .boundary_c(boundary_c),
        .commit_c  (commit_c)
    );

`ifdef HACK_SEQ_BREAKPOINT_EN
    assign bp_match_c = bp_en && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp  = ^{bp_en, bp_addr, pc};
    assign bp_match_c = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        steps_d       = steps_q;
        pend_halt_d   = pend_halt_q;
        pend_reset_d  = pend_reset_q;
        step_done_d   = 1'b0;
        bp_hit_d      = 1'b0;
        instr_count_d = instr_count;
        if (commit_c && !cpu_reset) begin
            instr_count_d = instr_count + CNT_W'(1);
        end
        unique case (state_q)
            RESET_HOLD: begin
                if (boundary_c) begin
                    if (steps_q == STEP_W'(STEPS_EFF - 1)) begin
                        steps_d = '0;
                        state_d = AUTORUN ? RUNNING : HALTED;
                    end else begin
                        steps_d = steps_q + STEP_W'(1);
                    end
                end
            end
            HALTED: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_RUN:   state_d = RUNNING;
                        CMD_STEP:  state_d = STEPPING;
                        CMD_RESET: state_d = RESET_HOLD;
                        default:   state_d = HALTED;
                    endcase
                end
            end
            RUNNING: begin
                // A request accepted on the boundary cycle itself takes effect at that boundary.
                if (accept && cmd == CMD_HALT)  pend_halt_d  = 1'b1;
                if (accept && cmd == CMD_RESET) pend_reset_d = 1'b1;
                if (boundary_c) begin
                    bp_hit_d = bp_match_c;
                    if (pend_reset_d) begin
                        state_d = RESET_HOLD;
                    end else if (pend_halt_d || bp_match_c) begin
                        state_d = HALTED;
                    end
                end
                if (state_d != RUNNING) begin
                    pend_halt_d  = 1'b0;
                    pend_reset_d = 1'b0;
                end
            end
            STEPPING: begin
                if (boundary_c) begin
                    state_d     = HALTED;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = RESET_HOLD;
        endcase
        if (state_d == RESET_HOLD && state_q != RESET_HOLD) begin
            instr_count_d = '0;
            steps_d       = '0;
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!reset_n) begin
            state_q      <= RESET_HOLD;
            steps_q      <= '0;
            pend_halt_q  <= 1'b0;
            pend_reset_q <= 1'b0;
            cmd_ready    <= 1'b0;
            cpu_reset    <= 1'b1;
            halted       <= 1'b0;
            step_done    <= 1'b0;
            bp_hit       <= 1'b0;
            instr_count  <= '0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            pend_halt_q  <= pend_halt_d;
            pend_reset_q <= pend_reset_d;
            cmd_ready    <= (state_d == HALTED) ||
                            (state_d == RUNNING && !pend_halt_d && !pend_reset_d);
            cpu_reset    <= (state_d == RESET_HOLD);
            halted       <= (state_d == HALTED);
            step_done    <= step_done_d;
            bp_hit       <= bp_hit_d;
            instr_count  <= instr_count_d;
        end
    end

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Self-checking bench for hack_cpu_sequencer: directed scenarios plus random commands,
// all compared every cycle against a behavioural run-control model.
module tb_hack_cpu_sequencer;

    localparam int unsigned DIV = 20;
    localparam int unsigned RS  = 2;

    logic        clk = 1'b0;
    logic        reset_n, cmd_valid, cmd_ready, bp_en;
    logic [1:0]  cmd;
    logic [15:0] pc, bp_addr;
    logic        CLK_CPU, cpu_reset, halted, step_done, bp_hit;
    logic [31:0] CLK_COUNT, instr_count;

    always #5 clk = ~clk;

    hack_cpu_sequencer #(.DIV(DIV), .RESET_STEPS(RS), .AUTORUN(1'b0)) dut (
        .CLK_100MHz (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .CLK_CPU    (CLK_CPU),
        .CLK_COUNT  (CLK_COUNT),
        .cpu_reset  (cpu_reset),
        .halted     (halted),
        .step_done  (step_done),
        .bp_hit     (bp_hit),
        .instr_count(instr_count)
    );

    // Model: mode 0=reset hold, 1=halted, 2=running, 3=stepping.
    int          m_mode, m_phase, m_periods;
    bit          m_ph, m_pr, m_sd, m_bh;
    bit [31:0]   m_ic;
    int          checks = 0, errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (m_mode == 1) || (m_mode == 2 && !m_ph && !m_pr);
    endfunction

    task automatic model_edge();
        bit acc, at_end, bp;
        if (!reset_n) begin
            m_mode = 0; m_phase = 0; m_periods = 0;
            m_ph = 0; m_pr = 0; m_sd = 0; m_bh = 0; m_ic = 0;
            return;
        end
        acc = cmd_valid && m_ready();
        m_sd = 0; m_bh = 0;
        if (m_mode == 1) begin
            if (acc && cmd == 2'd0) m_mode = 2;
            if (acc && cmd == 2'd2) m_mode = 3;
            if (acc && cmd == 2'd3) begin m_mode = 0; m_ic = 0; m_periods = 0; end
            return;
        end
        at_end = (m_phase == DIV - 1);
        if (m_mode != 0 && m_phase == DIV / 2) m_ic = m_ic + 1;
        if (m_mode == 2 && acc && cmd == 2'd1) m_ph = 1;
        if (m_mode == 2 && acc && cmd == 2'd3) m_pr = 1;
        m_phase = (m_phase + 1) % DIV;
        if (!at_end) return;
        if (m_mode == 0) begin
            m_periods++;
            if (m_periods == RS) begin m_mode = 1; m_periods = 0; end
        end else if (m_mode == 3) begin
            m_mode = 1; m_sd = 1;
        end else begin
`ifdef HACK_SEQ_BREAKPOINT_EN
            bp = bp_en && (pc == bp_addr);
`else
            bp = 0;
`endif
            m_bh = bp;
            if (m_pr) begin m_mode = 0; m_ic = 0; m_periods = 0; end
            else if (m_ph || bp) m_mode = 1;
            if (m_mode != 2) begin m_ph = 0; m_pr = 0; end
        end
    endtask

    task automatic check_outputs();
        chk("count",       CLK_COUNT,   32'(m_phase));
        chk("clk_cpu",     32'(CLK_CPU),   32'(m_phase >= DIV / 2));
        chk("cpu_reset",   32'(cpu_reset), 32'(m_mode == 0));
        chk("halted",      32'(halted),    32'(m_mode == 1));
        chk("cmd_ready",   32'(cmd_ready), 32'(m_ready()));
        chk("step_done",   32'(step_done), 32'(m_sd));
        chk("bp_hit",      32'(bp_hit),    32'(m_bh));
        chk("instr_count", instr_count, m_ic);
    endtask

    // CPU model: pc follows committed instruction count.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        pc = m_ic[15:0];
        check_outputs();
    endtask

    task automatic send(logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_count(int v);
        for (int i = 0; i < 200 && CLK_COUNT != 32'(v); i++) cycle();
        chk("wait_count", CLK_COUNT, 32'(v));
    endtask

    task automatic wait_halted(output int n, output int hi, output int bps);
        n = 0; hi = 0; bps = 0;
        while (!halted && n < 500) begin
            cycle();
            n++;
            if (CLK_CPU) hi++;
            if (bp_hit) bps++;
        end
    endtask

    initial begin
        int n, hi, bps;
        reset_n = 0; cmd_valid = 0; cmd = 0; pc = 0; bp_en = 0; bp_addr = 0;
        m_mode = 0; m_phase = 0; m_periods = 0; m_ph = 0; m_pr = 0; m_sd = 0; m_bh = 0; m_ic = 0;
        cycle(); cycle();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_count", CLK_COUNT, 32'd0);
        reset_n = 1;

        // Reset hold length.
        n = 0;
        while (cpu_reset && n < 200) begin cycle(); n++; end
        chk("hold_len", 32'(n), 32'(DIV * RS));
        chk("hold_halted", 32'(halted), 32'd1);
        chk("hold_ic", instr_count, 32'd0);

        // Single step.
        send(2'd2);
        wait_halted(n, hi, bps);
        chk("step_len", 32'(n), 32'(DIV));
        chk("step_cpu_high", 32'(hi), 32'(DIV / 2));
        chk("step_done_pulse", 32'(step_done), 32'd1);
        chk("step_ic", instr_count, 32'd1);

        // Run, halt requested mid-period.
        send(2'd0);
        wait_count(3);
        send(2'd1);
        chk("halt_ready_drop", 32'(cmd_ready), 32'd0);
        wait_halted(n, hi, bps);
        chk("halt_latency", 32'(n), 32'(DIV - 4));
        chk("halt_count", CLK_COUNT, 32'd0);

`ifdef HACK_SEQ_BREAKPOINT_EN
        send(2'd3);
        for (int i = 0; i < 200 && cpu_reset; i++) cycle();
        bp_en = 1; bp_addr = 16'h0005;
        send(2'd0);
        wait_halted(n, hi, bps);
        chk("bp_pulses", 32'(bps), 32'd1);
        chk("bp_ic", instr_count, 32'd5);
        bp_addr = 16'h0006;
        send(2'd0);
        wait_count(3);
        send(2'd1);
        wait_halted(n, hi, bps);
        chk("bp_halt_pulses", 32'(bps), 32'd1);
        chk("bp_halt_ic", instr_count, 32'd6);
        bp_en = 0;
`endif

        // Reset command while running.
        send(2'd0);
        wait_count(3);
        send(2'd3);
        for (int i = 0; i < 100 && !cpu_reset; i++) cycle();
        chk("rcmd_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rcmd_ic", instr_count, 32'd0);
        for (int i = 0; i < 200 && !halted; i++) cycle();

        // reset_n mid-step.
        send(2'd2);
        wait_count(12);
        reset_n = 0;
        cycle();
        chk("midstep_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midstep_count", CLK_COUNT, 32'd0);
        chk("midstep_halted", 32'(halted), 32'd0);
        reset_n = 1;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd       = 2'($urandom_range(0, 3));
            if (cmd == 2'd3 && $urandom_range(0, 3) != 0) cmd = 2'd0;
            bp_en     = ($urandom_range(0, 1) == 1);
            bp_addr   = m_ic[15:0] + 16'($urandom_range(0, 3));
            reset_n   = ($urandom_range(0, 599) != 0);
            cycle();
        end
        reset_n = 1; cmd_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
